// File: rtl/broadcast_scheduler.sv
// FIFO-fed driver for the 1-to-16 multibroadcasting stage: replays each queued request for HOLD cycles, then blanks pb.
// Optional completed-broadcast counter on sent_count when BCAST_SCHED_STATS_EN is defined.
module broadcast_scheduler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_data,
   input  logic [1:0] req_line,
   input  logic [3:0] req_ports,
   output logic       inp,
   output logic [0:3] pb,
   output logic [1:0] lb,
`ifdef BCAST_SCHED_STATS_EN
   output logic [7:0] sent_count,
`endif
   output logic       busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

   state_t          state, state_nxt;
   logic [6:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [TW-1:0]   timer, timer_nxt;
   logic            push, pop;
   logic            inp_nxt;
   logic [0:3]      pb_nxt;
   logic [1:0]      lb_nxt;
   logic [6:0]      head;

   assign req_ready = (count != CW'(DEPTH));
   assign push      = req_valid & req_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (count != '0) || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {req_data, req_line, req_ports};
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      timer_nxt = timer;
      inp_nxt   = inp;
      pb_nxt    = pb;
      lb_nxt    = lb;
      case (state)
         IDLE, GAP: begin
            pb_nxt    = '0;
            state_nxt = IDLE;
            if (count != '0) begin
               pop       = 1'b1;
               inp_nxt   = head[6];
               lb_nxt    = head[5:4];
               for (int unsigned i = 0; i < 4; i++)
                  pb_nxt[i] = head[i];
               timer_nxt = TW'(HOLD - 1);
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (timer == '0) begin
               pb_nxt    = '0;
               state_nxt = GAP;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         inp   <= 1'b0;
         pb    <= '0;
         lb    <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         inp   <= inp_nxt;
         pb    <= pb_nxt;
         lb    <= lb_nxt;
      end
   end

`ifdef BCAST_SCHED_STATS_EN
   logic done;
   assign done = (state == DRIVE) && (timer == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sent_count <= '0;
      else if (done && (sent_count != 8'hFF))
         sent_count <= sent_count + 8'd1;
   end
`endif

endmodule
